// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for an RV32 subset datapath: instruction decode, state sequencing, enables.
// Define MC_PERF_CNT_EN to add the cycle_cnt / instret_cnt performance counters.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16
`ifdef MC_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        mem_ready,
    output logic        RWen,
    output logic        memRW,
    output logic        beq_control,
    output logic        bne_control,
    output logic        jump,
    output logic        ALUsel,
    output logic [1:0]  Immsel,
    output logic        Asel,
    output logic        Bsel,
    output logic [1:0]  WBsel,
    output logic        pc_we,
    output logic        ir_we,
    output logic        halted,
    output logic        bus_err,
    output logic [2:0]  state_o
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_I, C_LW, C_SW, C_BEQ, C_BNE, C_JAL, C_ILL
    } iclass_t;

    localparam int                WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam bit                TIMEOUT_EN = (MEM_TIMEOUT > 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                bus_err_q, bus_err_d;

    iclass_t             iclass;
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic                rd_nz;
    logic                unused_instr_bits;

    assign opcode            = instruction[6:0];
    assign funct3            = instruction[14:12];
    assign rd_nz             = |instruction[11:7];
    assign unused_instr_bits = ^{instruction[31], instruction[29:15]};

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        iclass = C_ILL;
        ALUsel = 1'b0;
        Immsel = 2'b00;
        Asel   = 1'b0;
        Bsel   = 1'b0;
        WBsel  = 2'b01;
        case (opcode)
            7'b0110011: begin iclass = C_R;  ALUsel = instruction[30]; end
            7'b0010011: begin iclass = C_I;  Bsel = 1'b1; end
            7'b0000011: begin iclass = C_LW; Bsel = 1'b1; WBsel = 2'b00; end
            7'b0100011: begin iclass = C_SW; Immsel = 2'b01; Bsel = 1'b1; end
            7'b1100011: begin
                Immsel = 2'b10;
                Asel   = 1'b1;
                Bsel   = 1'b1;
                case (funct3)
                    3'b000:  iclass = C_BEQ;
                    3'b001:  iclass = C_BNE;
                    default: iclass = C_ILL;
                endcase
            end
            7'b1101111: begin iclass = C_JAL; Immsel = 2'b11; WBsel = 2'b10; end
            default:    iclass = C_ILL;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = '0;
        bus_err_d   = bus_err_q;
        RWen        = 1'b0;
        memRW       = 1'b0;
        beq_control = 1'b0;
        bne_control = 1'b0;
        jump        = 1'b0;
        pc_we       = 1'b0;
        ir_we       = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_we   = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: state_d = (iclass == C_ILL) ? S_HALT : S_EXEC;
            S_EXEC: begin
                case (iclass)
                    C_BEQ: begin beq_control = 1'b1; pc_we = 1'b1; state_d = S_FETCH; end
                    C_BNE: begin bne_control = 1'b1; pc_we = 1'b1; state_d = S_FETCH; end
                    C_JAL: begin
                        jump    = 1'b1;
                        pc_we   = 1'b1;
                        RWen    = rd_nz;
                        state_d = S_FETCH;
                    end
                    C_R, C_I:   state_d = S_WB;
                    C_LW, C_SW: state_d = S_MEM;
                    default:    state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                memRW = (iclass == C_SW);
                if (mem_ready) begin
                    if (iclass == C_SW) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (TIMEOUT_EN && (wait_cnt_q == WAIT_LAST)) begin
                    // Abort the access: the store strobe is withdrawn in the timeout cycle.
                    memRW     = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end else if (TIMEOUT_EN) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                RWen    = rd_nz;
                pc_we   = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase

        if (reset) begin
            RWen        = 1'b0;
            memRW       = 1'b0;
            beq_control = 1'b0;
            bne_control = 1'b0;
            jump        = 1'b0;
            pc_we       = 1'b0;
            ir_we       = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign halted  = (state_q == S_HALT);
    assign bus_err = bus_err_q;
    assign state_o = state_q;

`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q + ((state_q != S_HALT) ? CNT_W'(1) : CNT_W'(0));
        instret_cnt_d = instret_cnt_q + CNT_W'(pc_we);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed instructions push expected retire/halt records,
// a negedge monitor tracks each instruction from ir_we to its pc_we or HALT and compares.
module tb_multicycle_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] instruction;
    logic        mem_ready;
    logic        RWen, memRW, beq_control, bne_control, jump, ALUsel, Asel, Bsel;
    logic [1:0]  Immsel, WBsel;
    logic        pc_we, ir_we, halted, bus_err;
    logic [2:0]  state_o;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    multicycle_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .mem_ready   (mem_ready),
        .RWen        (RWen),
        .memRW       (memRW),
        .beq_control (beq_control),
        .bne_control (bne_control),
        .jump        (jump),
        .ALUsel      (ALUsel),
        .Immsel      (Immsel),
        .Asel        (Asel),
        .Bsel        (Bsel),
        .WBsel       (WBsel),
        .pc_we       (pc_we),
        .ir_we       (ir_we),
        .halted      (halted),
        .bus_err     (bus_err),
        .state_o     (state_o)
`ifdef MC_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Control snapshot: {RWen,memRW,beq,bne,jump,ALUsel,Immsel[1:0],Asel,Bsel,WBsel[1:0],halted,bus_err}
    localparam logic [13:0] M_ALL  = 14'h3FFF;
    localparam logic [13:0] M_HALT = 14'h3E03;
    localparam logic [13:0] DC_ALU = 14'h0100;
    localparam logic [13:0] DC_IMM = 14'h00C0;
    localparam logic [13:0] DC_A   = 14'h0020;
    localparam logic [13:0] DC_B   = 14'h0010;
    localparam logic [13:0] DC_WB  = 14'h000C;

    typedef struct {
        string       name;
        int          cycles;
        int          rwen_n;
        int          mem_n;
        int          memrw_n;
        logic [13:0] ctl;
        logic [13:0] mask;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [13:0] ctl_now;
    assign ctl_now = {RWen, memRW, beq_control, bne_control, jump, ALUsel, Immsel,
                      Asel, Bsel, WBsel, halted, bus_err};

    function automatic logic [13:0] mk(input logic rw, input logic mrw, input logic bq,
                                       input logic bn, input logic jp, input logic alu,
                                       input logic [1:0] imm, input logic a, input logic b,
                                       input logic [1:0] wb, input logic h, input logic be);
        return {rw, mrw, bq, bn, jp, alu, imm, a, b, wb, h, be};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: follows one instruction at a time and scores it when it retires or halts.
    bit in_flight    = 1'b0;
    bit expect_fetch = 1'b0;
    int cyc, rwen_n, mem_n, memrw_n;

    always @(negedge clk) begin
        if (reset) begin
            in_flight    = 1'b0;
            expect_fetch = 1'b0;
        end else begin
            if (expect_fetch) begin
                check("fetch_after_retire", {ir_we, state_o}, {1'b1, 3'd0});
                expect_fetch = 1'b0;
            end
            if (ir_we) begin
                check("ir_we_while_busy", in_flight, 0);
                in_flight = 1'b1;
                cyc       = 0;
                rwen_n    = 0;
                mem_n     = 0;
                memrw_n   = 0;
            end
            if (in_flight) begin
                cyc++;
                if (RWen) rwen_n++;
                if (state_o == 3'd3) begin
                    mem_n++;
                    if (memRW) memrw_n++;
                end
                if (pc_we || halted) begin
                    check("sb_has_entry", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check({e.name, ".cycles"},  cyc,     e.cycles);
                        check({e.name, ".rwen_n"},  rwen_n,  e.rwen_n);
                        check({e.name, ".mem_n"},   mem_n,   e.mem_n);
                        check({e.name, ".memrw_n"}, memrw_n, e.memrw_n);
                        check({e.name, ".ctl"}, ctl_now & e.mask, e.ctl & e.mask);
                    end
                    in_flight    = 1'b0;
                    expect_fetch = pc_we;
                end
            end else begin
                check("idle_pc_we", pc_we, 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset     = 1'b1;
        mem_ready = 1'b0;
        #1;
        check("reset.enables", {RWen, memRW, pc_we, ir_we, beq_control, bne_control, jump}, 0);
        step();
        step();
        reset = 1'b0;
        check("reset.state",   state_o, 0);
        check("reset.halted",  halted,  0);
        check("reset.bus_err", bus_err, 0);
    endtask

    // Presents one instruction in FETCH and answers DMEM after 'delay' not-ready MEM cycles.
    task automatic run(input string nm, input logic [31:0] ins, input int delay,
                       input int cycles, input int rw_n, input int m_n, input int mrw_n,
                       input logic [13:0] ctl, input logic [13:0] mask);
        exp_t e;
        int   b;
        int   waited;
        e.name = nm; e.cycles = cycles; e.rwen_n = rw_n; e.mem_n = m_n;
        e.memrw_n = mrw_n; e.ctl = ctl; e.mask = mask;
        exp_q.push_back(e);

        b = 0;
        while (state_o != 3'd0 && b < 50) begin step(); b++; end
        check({nm, ".in_fetch"}, state_o, 0);

        instruction = ins;
        mem_ready   = (delay == 0);
        waited      = 0;
        step();
        b = 0;
        while (!(state_o == 3'd0 || state_o == 3'd5) && b < 100) begin
            if (state_o == 3'd3 && !mem_ready) begin
                if (waited == delay) mem_ready = 1'b1;
                else waited++;
            end
            step();
            b++;
        end
        check({nm, ".completed"}, b < 100, 1);
        mem_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int b;
        reset       = 1'b1;
        instruction = 32'h0;
        mem_ready   = 1'b0;
        do_reset();

        run("add",    32'h002081B3, 0, 4, 1, 0, 0,
            mk(1,0,0,0,0,0,2'b00,0,0,2'b01,0,0), M_ALL & ~DC_IMM);
        run("sub",    32'h402081B3, 0, 4, 1, 0, 0,
            mk(1,0,0,0,0,1,2'b00,0,0,2'b01,0,0), M_ALL & ~DC_IMM);
        run("sub_x0", 32'h40208033, 0, 4, 0, 0, 0,
            mk(0,0,0,0,0,1,2'b00,0,0,2'b01,0,0), M_ALL & ~DC_IMM);
        run("addi",   32'h00500093, 0, 4, 1, 0, 0,
            mk(1,0,0,0,0,0,2'b00,0,1,2'b01,0,0), M_ALL & ~DC_A);
        run("lw_wait2", 32'h00802283, 2, 7, 1, 3, 0,
            mk(1,0,0,0,0,0,2'b00,0,1,2'b00,0,0), M_ALL & ~(DC_A | DC_ALU));
        run("lw_fast",  32'h00802283, 0, 5, 1, 1, 0,
            mk(1,0,0,0,0,0,2'b00,0,1,2'b00,0,0), M_ALL & ~(DC_A | DC_ALU));
        run("sw_wait1", 32'h00502623, 1, 5, 0, 2, 2,
            mk(0,1,0,0,0,0,2'b01,0,1,2'b00,0,0), M_ALL & ~(DC_A | DC_ALU | DC_WB));
        run("sw_fast",  32'h00502623, 0, 4, 0, 1, 1,
            mk(0,1,0,0,0,0,2'b01,0,1,2'b00,0,0), M_ALL & ~(DC_A | DC_ALU | DC_WB));
        run("beq",    32'h00208463, 0, 3, 0, 0, 0,
            mk(0,0,1,0,0,0,2'b10,1,1,2'b00,0,0), M_ALL & ~DC_WB);
        run("bne",    32'h00209463, 0, 3, 0, 0, 0,
            mk(0,0,0,1,0,0,2'b10,1,1,2'b00,0,0), M_ALL & ~DC_WB);
        run("jal",    32'h010000EF, 0, 3, 1, 0, 0,
            mk(1,0,0,0,1,0,2'b11,0,0,2'b10,0,0), M_ALL & ~(DC_A | DC_B | DC_ALU));
        run("jal_x0", 32'h0100006F, 0, 3, 0, 0, 0,
            mk(0,0,0,0,1,0,2'b11,0,0,2'b10,0,0), M_ALL & ~(DC_A | DC_B | DC_ALU));

        run("bad_funct3", 32'h0020A463, 0, 3, 0, 0, 0,
            mk(0,0,0,0,0,0,2'b00,0,0,2'b00,1,0), M_HALT);
        step();
        do_reset();
        run("zero_word", 32'h00000000, 0, 3, 0, 0, 0,
            mk(0,0,0,0,0,0,2'b00,0,0,2'b00,1,0), M_HALT);
        step();
        do_reset();
        run("lw_timeout", 32'h00802283, 1000, 20, 0, 16, 0,
            mk(0,0,0,0,0,0,2'b00,0,0,2'b00,1,1), M_HALT);
        step();
        do_reset();

        // Store stalled in MEM, then reset: the aborted store must not leave any enable behind.
        instruction = 32'h00502623;
        mem_ready   = 1'b0;
        b = 0;
        while (state_o != 3'd3 && b < 20) begin step(); b++; end
        check("rst_mem.reached_mem", state_o, 3);
        step();
        step();
        check("rst_mem.memrw_held", {state_o, memRW}, {3'd3, 1'b1});
        reset = 1'b1;
        #1;
        check("rst_mem.enables", {RWen, memRW, pc_we, ir_we, beq_control, bne_control, jump}, 0);
        step();
        reset = 1'b0;
        check("rst_mem.state",   state_o, 0);
        check("rst_mem.bus_err", bus_err, 0);

        run("add_after_abort", 32'h002081B3, 0, 4, 1, 0, 0,
            mk(1,0,0,0,0,0,2'b00,0,0,2'b01,0,0), M_ALL & ~DC_IMM);

        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
